// File: rtl/servo_pkg.sv
// Shared constants and pulse-width helper for the servo PWM subsystem.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Defaults assume a 50 MHz core clock: 20 ms frame, 1 ms minimum pulse and
// 196 cycles per position LSB, so position 255 gives roughly 2 ms.
package servo_pkg;

    localparam int FRAME_TICKS_50M = 1000000;
    localparam int MIN_TICKS_50M   = 50000;
    localparam int STEP_TICKS_50M  = 196;
    localparam int RESET_POS       = 128;

    // Pulse width in clock cycles for a given position code.
    function automatic logic [31:0] width_ticks(
        input logic [31:0] pos,
        input logic [31:0] min_ticks,
        input logic [31:0] step_ticks
    );
        return min_ticks + pos * step_ticks;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: target/current position, per-frame slew and pulse compare.
// Latency: pwm/at_target registered, one cycle behind the shared frame counter.
// Backpressure: none; writes are accepted unconditionally when i_wr is high.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_fcnt        shared frame counter value
//   i_update      frame-boundary strobe (last cycle of the frame)
//   i_wr/i_wr_pos target write strobe and new target position
//   o_pwm         servo pulse output
//   o_at_target   high when current position equals target
module servo_channel #(
    parameter int POS_W      = 8,
    parameter int MIN_TICKS  = servo_pkg::MIN_TICKS_50M,
    parameter int STEP_TICKS = servo_pkg::STEP_TICKS_50M,
    parameter int SLEW       = 4,
    parameter int RESET_POS  = servo_pkg::RESET_POS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_fcnt,
    input  logic             i_update,
    input  logic             i_wr,
    input  logic [POS_W-1:0] i_wr_pos,
    output logic             o_pwm,
    output logic             o_at_target
);
    import servo_pkg::*;

    localparam logic [POS_W-1:0] RST_POS = POS_W'(RESET_POS);
    localparam logic [POS_W-1:0] SLEW_P  = POS_W'(SLEW);
    localparam logic [31:0]      SLEW_U  = 32'(SLEW);

    logic [POS_W-1:0]        r_target;
    logic [POS_W-1:0]        r_cur;
    logic                    r_pwm;
    logic                    r_at_target;
    logic signed [POS_W:0]   w_diff;
    logic [POS_W:0]          w_mag;
    logic [POS_W-1:0]        w_cur_next;
    logic [31:0]             w_width;

    // Slew step: jump straight to target when close enough (or unlimited),
    // otherwise move exactly SLEW toward it. Because the step is only taken
    // when |d| > SLEW, cur can neither overshoot nor wrap.
    always_comb begin
        w_diff     = $signed({1'b0, r_target}) - $signed({1'b0, r_cur});
        w_mag      = w_diff[POS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_cur_next = r_target;
        if ((SLEW_U != 32'd0) && (32'(w_mag) > SLEW_U)) begin
            if (w_diff[POS_W]) begin
                w_cur_next = r_cur - SLEW_P;
            end else begin
                w_cur_next = r_cur + SLEW_P;
            end
        end
    end

    // cur only changes on the last cycle of a frame, so the width is stable
    // for the whole of the following frame.
    assign w_width = width_ticks(32'(r_cur), 32'(MIN_TICKS), 32'(STEP_TICKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target    <= RST_POS;
            r_cur       <= RST_POS;
            r_pwm       <= 1'b0;
            r_at_target <= 1'b1;
        end else begin
            if (i_wr) begin
                r_target <= i_wr_pos;
            end
            // A write in the update cycle lands in r_target, while this
            // update still reads the old r_target.
            if (i_update) begin
                r_cur <= w_cur_next;
            end
            r_pwm       <= (i_fcnt < w_width);
            r_at_target <= (r_cur == r_target);
        end
    end

    assign o_pwm       = r_pwm;
    assign o_at_target = r_at_target;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM bank with host-commanded, rate-limited motion.
// Latency: outputs one cycle behind fcnt; new targets show from the next frame.
// Backpressure: cmd_ready is high whenever out of reset; one command per cycle.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_chan/cmd_pos               target channel and position code
//   cmd_err                        pulse after accepting an out-of-range channel
//   pwm                            per-channel servo pulses
//   frame_start                    pulse on the first output cycle of each frame
//   at_target                      per-channel current == target
module servo_pwm_bank #(
    parameter int  CHANNELS    = 4,
    parameter int  POS_W       = 8,
    parameter int  FRAME_TICKS = servo_pkg::FRAME_TICKS_50M,
    parameter int  MIN_TICKS   = servo_pkg::MIN_TICKS_50M,
    parameter int  STEP_TICKS  = servo_pkg::STEP_TICKS_50M,
    parameter int  SLEW        = 4,
    parameter int  RESET_POS   = servo_pkg::RESET_POS,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [POS_W-1:0]    cmd_pos,
    output logic                cmd_err,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic [CHANNELS-1:0] at_target
);
    import servo_pkg::*;

    // Configuration sanity: the widest pulse must fit inside one frame.
    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
        $error("servo_pwm_bank: CHANNELS must be 1..16");
    end
    if (MIN_TICKS + ((1 << POS_W) - 1) * STEP_TICKS >= FRAME_TICKS) begin : g_bad_timing
        $error("servo_pwm_bank: maximum pulse width does not fit in a frame");
    end

    logic [31:0] r_fcnt;
    logic        r_cmd_ready;
    logic        r_cmd_err;
    logic        r_frame_start;
    logic        w_accept;
    logic        w_chan_bad;
    logic        w_update;

    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_chan_bad = (32'(cmd_chan) >= 32'(CHANNELS));
    assign w_update   = (r_fcnt == 32'(FRAME_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt        <= 32'd0;
            r_cmd_ready   <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_fcnt        <= w_update ? 32'd0 : r_fcnt + 32'd1;
            r_cmd_ready   <= 1'b1;
            r_cmd_err     <= w_accept && w_chan_bad;
            r_frame_start <= (r_fcnt == 32'd0);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic w_wr;
        assign w_wr = w_accept && !w_chan_bad && (32'(cmd_chan) == 32'(gi));

        servo_channel #(
            .POS_W      (POS_W),
            .MIN_TICKS  (MIN_TICKS),
            .STEP_TICKS (STEP_TICKS),
            .SLEW       (SLEW),
            .RESET_POS  (RESET_POS)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_fcnt      (r_fcnt),
            .i_update    (w_update),
            .i_wr        (w_wr),
            .i_wr_pos    (cmd_pos),
            .o_pwm       (pwm[gi]),
            .o_at_target (at_target[gi])
        );
    end

    assign cmd_ready   = r_cmd_ready;
    assign cmd_err     = r_cmd_err;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: reset state, frame period, pulse widths,
// slew ramp, unlimited slew, bad channel index, boundary collision, mid-frame reset.
// Two instances share clk/rst so their frames stay aligned: u_a is the
// 4-channel SLEW=4 bank; u_b is a 5-channel SLEW=0 bank whose 3-bit channel
// field can actually carry the out-of-range index 5.
module tb_servo_pwm_bank;
    import servo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;

    logic       a_cmd_valid = 1'b0;
    logic       a_cmd_ready;
    logic [1:0] a_cmd_chan = '0;
    logic [7:0] a_cmd_pos = '0;
    logic       a_cmd_err;
    logic [3:0] a_pwm;
    logic       a_frame_start;
    logic [3:0] a_at_target;

    logic       b_cmd_valid = 1'b0;
    logic       b_cmd_ready;
    logic [2:0] b_cmd_chan = '0;
    logic [7:0] b_cmd_pos = '0;
    logic       b_cmd_err;
    logic [4:0] b_pwm;
    logic       b_frame_start;
    logic [4:0] b_at_target;

    servo_pwm_bank #(
        .CHANNELS(4), .POS_W(8), .FRAME_TICKS(1000), .MIN_TICKS(100),
        .STEP_TICKS(2), .SLEW(4), .RESET_POS(128)
    ) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_chan(a_cmd_chan), .cmd_pos(a_cmd_pos), .cmd_err(a_cmd_err),
        .pwm(a_pwm), .frame_start(a_frame_start), .at_target(a_at_target)
    );

    servo_pwm_bank #(
        .CHANNELS(5), .POS_W(8), .FRAME_TICKS(1000), .MIN_TICKS(100),
        .STEP_TICKS(2), .SLEW(0), .RESET_POS(128)
    ) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_chan(b_cmd_chan), .cmd_pos(b_cmd_pos), .cmd_err(b_cmd_err),
        .pwm(b_pwm), .frame_start(b_frame_start), .at_target(b_at_target)
    );

    typedef struct {
        int k;
        bit to_b;
        int chan;
        int pos;
    } cmd_t;

    cmd_t       cmd_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         wa[4];
    int         wb[5];
    int         err_a;
    int         err_b;
    logic [3:0] at_a_mid;
    logic [4:0] at_b_mid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bounded wait for the next frame_start, sampled on negedges.
    task automatic wait_fs(input string tag);
        int n = 0;
        while (!a_frame_start && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(a_frame_start), 32'd1);
    endtask

    // Entered on the negedge where frame_start is high. Sample k of the frame
    // reflects fcnt==k; a command driven at sample k is accepted with fcnt==k+1.
    task automatic run_frame(input string tag);
        int fs_seen = 0;
        err_a = 0;
        err_b = 0;
        for (int i = 0; i < 4; i++) wa[i] = 0;
        for (int i = 0; i < 5; i++) wb[i] = 0;
        for (int k = 0; k < 1000; k++) begin
            if (a_frame_start) fs_seen++;
            for (int i = 0; i < 4; i++) wa[i] += int'(a_pwm[i]);
            for (int i = 0; i < 5; i++) wb[i] += int'(b_pwm[i]);
            if (a_cmd_err) err_a++;
            if (b_cmd_err) err_b++;
            if (k == 500) begin
                at_a_mid = a_at_target;
                at_b_mid = b_at_target;
            end
            a_cmd_valid = 1'b0;
            b_cmd_valid = 1'b0;
            foreach (cmd_q[j]) begin
                if (cmd_q[j].k == k) begin
                    if (cmd_q[j].to_b) begin
                        b_cmd_valid = 1'b1;
                        b_cmd_chan  = 3'(cmd_q[j].chan);
                        b_cmd_pos   = 8'(cmd_q[j].pos);
                    end else begin
                        a_cmd_valid = 1'b1;
                        a_cmd_chan  = 2'(cmd_q[j].chan);
                        a_cmd_pos   = 8'(cmd_q[j].pos);
                    end
                end
            end
            @(negedge clk);
        end
        cmd_q.delete();
        chk({tag, "_fs_once"}, 32'(fs_seen), 32'd1);
        chk({tag, "_period_a"}, 32'(a_frame_start), 32'd1);
        chk({tag, "_period_b"}, 32'(b_frame_start), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int ea0, input int ea1,
                             input int ea2, input int ea3, input int eb2);
        int ea[4];
        ea = '{ea0, ea1, ea2, ea3};
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_wa%0d", tag, i), 32'(wa[i]), 32'(ea[i]));
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_wb%0d", tag, i), 32'(wb[i]), (i == 2) ? 32'(eb2) : 32'd356);
    endtask

    initial begin
        // Reset held across three rising edges.
        repeat (3) @(negedge clk);
        chk("rst_pwm_a",   32'(a_pwm), 32'd0);
        chk("rst_pwm_b",   32'(b_pwm), 32'd0);
        chk("rst_fs",      32'(a_frame_start), 32'd0);
        chk("rst_ready",   32'(a_cmd_ready), 32'd0);
        chk("rst_err",     32'(a_cmd_err), 32'd0);
        chk("rst_at_a",    32'(a_at_target), 32'hF);
        chk("rst_at_b",    32'(b_at_target), 32'h1F);
        chk("width_fn",    width_ticks(32'd128, 32'd100, 32'd2), 32'd356);

        rst = 1'b0;
        @(negedge clk);
        chk("rel_fs",      32'(a_frame_start), 32'd1);
        chk("rel_ready",   32'(a_cmd_ready), 32'd1);
        chk("rel_pwm",     32'(a_pwm), 32'hF);

        // F1: ch2:=0 on the unlimited bank, bad index 5, ch0:=140 on the slewed bank.
        cmd_q.push_back('{k: 10, to_b: 1'b1, chan: 2, pos: 0});
        cmd_q.push_back('{k: 20, to_b: 1'b1, chan: 5, pos: 77});
        cmd_q.push_back('{k: 30, to_b: 1'b0, chan: 0, pos: 140});
        run_frame("f1");
        chk_frame("f1", 356, 356, 356, 356, 356);
        chk("f1_err_b",  32'(err_b), 32'd1);
        chk("f1_err_a",  32'(err_a), 32'd0);
        chk("f1_at_a",   32'(at_a_mid), 32'b1110);
        chk("f1_at_b",   32'(at_b_mid), 32'b11011);

        // F2: ch1:=200 accepted in the fcnt==999 cycle.
        cmd_q.push_back('{k: 998, to_b: 1'b0, chan: 1, pos: 200});
        run_frame("f2");
        chk_frame("f2", 364, 356, 356, 356, 100);
        chk("f2_at_a",   32'(at_a_mid), 32'b1110);
        chk("f2_at_b",   32'(at_b_mid), 32'h1F);

        run_frame("f3");
        chk_frame("f3", 372, 356, 356, 356, 100);
        chk("f3_at_a",   32'(at_a_mid), 32'b1100);

        run_frame("f4");
        chk_frame("f4", 380, 364, 356, 356, 100);
        chk("f4_at_a",   32'(at_a_mid), 32'b1101);

        // Mid-frame reset with fcnt==50 while all pulses are high.
        repeat (49) @(negedge clk);
        chk("pre_rst_pwm", 32'(a_pwm), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm_a", 32'(a_pwm), 32'd0);
        chk("mid_rst_pwm_b", 32'(b_pwm), 32'd0);
        chk("mid_rst_ready", 32'(a_cmd_ready), 32'd0);
        chk("mid_rst_at_a",  32'(a_at_target), 32'hF);
        rst = 1'b0;
        wait_fs("post_rst_fs");

        run_frame("f6");
        chk_frame("f6", 356, 356, 356, 356, 356);
        chk("f6_at_a",   32'(at_a_mid), 32'hF);
        chk("f6_at_b",   32'(at_b_mid), 32'h1F);

        run_frame("f7");
        chk_frame("f7", 356, 356, 356, 356, 356);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
